seq_mag_compare: RTL
====================

Name: seq_mag_compare

Overview:
- Parametrised, sequential successor to the team's fixed 16-bit nibble-sliced magnitude comparator.
- Compares two WIDTH-bit operands MSB-first, one DIGIT-bit slice per cycle.
- Supports an unsigned/signed mode and optional early exit on the first differing slice.
- Produces a one-hot lt/eq/gt result behind valid/ready handshakes. Sits between operand-producing datapath stages and control logic that consumes compare results.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least DIGIT.
- DIGIT, 4, slice width compared per cycle. NDIG = WIDTH/DIGIT.
- EARLY_EXIT, 1, 1 = finish on the first unequal slice; 0 = always scan all NDIG slices (fixed latency).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_signed  in  1  1 = two's-complement compare; sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_lt  out  1  A < B.
- out_eq  out  1  A == B.
- out_gt  out  1  A > B.
- out_cycles  out  clog2(NDIG)+1  number of slices scanned for this result.

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1 once rst deasserts; out_valid=0; out_lt/out_eq/out_gt=0; out_cycles=0; operand registers and slice index are cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register A, B and signed, set idx=NDIG-1, go to SCAN.
  - SCAN: in_ready=0. Compare slice idx of the registered A and B.
    - Slice unequal and EARLY_EXIT=1: latch lt/gt, go to DONE.
    - Otherwise, idx==0: latch the final lt/eq/gt (eq only if every slice was equal), go to DONE.
    - Otherwise: decrement idx and stay in SCAN.
    - With EARLY_EXIT=0, the first unequal slice's verdict is held and later slices cannot overwrite it.
  - DONE: out_valid=1. Result and out_cycles stay stable until out_valid&out_ready.
    - On that handshake: if in_valid is also 1, accept the new operands in the same cycle and go to SCAN; otherwise go to IDLE.
    - in_ready = out_ready while in DONE. This is the only permitted combinational in_ready path.
- Signed mode: invert bit WIDTH-1 of both registered operands (offset-binary) before slicing. Unsigned slice compare is then exact.
- Latency: operands accepted at edge t; the result is first valid in the cycle after edge t+1+k, where k = slices scanned − 1.
  - Equal operands: out_cycles=NDIG.
  - First differing slice is the top one with EARLY_EXIT=1: out_cycles=1.
- One-hot guarantee: exactly one of lt/eq/gt is 1 whenever out_valid=1. All three are 0 when out_valid=0.
- Operand changes on in_a/in_b/in_signed during SCAN are ignored, because the operands are registered at accept.
- rst asserted mid-SCAN or in DONE aborts immediately to reset values. The pending result is lost and no out_valid pulse follows.
- WIDTH==DIGIT (NDIG=1): SCAN lasts exactly one cycle.

Decomposition:
- Package comp_pkg:
  - state enum {IDLE, SCAN, DONE};
  - result encoding constants CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001;
  - function computing NDIG and the idx width.
- Sub-module cmp_digit: purely combinational DIGIT-bit unsigned compare producing lt/eq/gt. Instantiated once and fed by a slice mux on idx.
- Top level holds the FSM, operand registers, idx counter, result register and out_cycles counter.

Test Plan:
- WIDTH=16, DIGIT=4, EARLY_EXIT=1, unsigned; A=0x1234, B=0x1234 -> out_eq=1, out_cycles=4, out_valid in the 5th cycle after accept.
- Unsigned A=0x8000, B=0x7FFF -> out_gt=1, out_cycles=1. Same operands with in_signed=1 -> out_lt=1, out_cycles=1.
- A=0x0001, B=0x0002, once with EARLY_EXIT=1 and once with EARLY_EXIT=0 -> out_lt=1, out_cycles=4 in both. Also A=0x1000, B=0x2000 with EARLY_EXIT=0 -> out_lt=1, out_cycles=4 (the later equal slices do not overwrite the verdict).
- Back-to-back: hold out_ready=0 for 3 cycles in DONE -> result and out_cycles stable, in_ready=0. Then out_ready=1 with in_valid=1 -> second pair accepted that same cycle, and the second result is correct.
- Assert rst for 1 cycle while in SCAN with idx=2 -> out_valid=0 and in_ready=1 after release, no stale result. A fresh compare of A=0xFFFF, B=0x0000 signed -> out_lt=1.
- Randomised: 10k pairs over both modes with random out_ready stalls, checked against a golden compare -> always exactly one hot output and no dropped or duplicated results.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Result encoding is one-hot {lt, eq, gt}; all-zero means "no result".
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CMP_LT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_GT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Index register keeps at least one bit even when there is a single slice.
    function automatic int calc_idx_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    output logic             o_lt,
    output logic             o_eq,
    output logic             o_gt
);

    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/seq_mag_compare.sv
// MSB-first slice-serial magnitude comparator with signed/unsigned mode,
// optional early exit and valid/ready handshakes on both sides.
module seq_mag_compare
    import comp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_a,
    input  logic [WIDTH-1:0]                in_b,
    input  logic                            in_signed,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_lt,
    output logic                            out_eq,
    output logic                            out_gt,
    output logic [$clog2(WIDTH/DIGIT):0]    out_cycles
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int IW   = calc_idx_w(NDIG);
    localparam int CW   = $clog2(NDIG) + 1;
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = ONE_W << (WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [2:0]       r_res;
    logic [2:0]       r_held;
    logic             r_found;
    logic [CW-1:0]    r_cycles;
    logic             r_valid;

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_load_a;
    logic [WIDTH-1:0] w_load_b;
    logic [DIGIT-1:0] w_slice_a;
    logic [DIGIT-1:0] w_slice_b;
    logic             w_lt;
    logic             w_eq;
    logic             w_gt;
    logic [2:0]       w_verdict;

    // Signed operands become offset-binary so the unsigned slice compare is exact.
    assign w_mask    = in_signed ? MSB_MASK : {WIDTH{1'b0}};
    assign w_load_a  = in_a ^ w_mask;
    assign w_load_b  = in_b ^ w_mask;
    assign w_slice_a = r_a[int'(r_idx) * DIGIT +: DIGIT];
    assign w_slice_b = r_b[int'(r_idx) * DIGIT +: DIGIT];

    cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
        .i_a  (w_slice_a),
        .i_b  (w_slice_b),
        .o_lt (w_lt),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    assign w_verdict = w_lt ? CMP_LT : (w_gt ? CMP_GT : CMP_EQ);

    // Upstream ready: free in IDLE, follows the consumer while a result is pending.
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            IDLE:    in_ready = 1'b1;
            SCAN:    in_ready = 1'b0;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Control FSM, operand/index registers and result/cycle registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_idx    <= {IW{1'b0}};
            r_res    <= CMP_NONE;
            r_held   <= CMP_NONE;
            r_found  <= 1'b0;
            r_cycles <= {CW{1'b0}};
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= w_load_a;
                        r_b      <= w_load_b;
                        r_idx    <= IW'(NDIG - 1);
                        r_found  <= 1'b0;
                        r_held   <= CMP_NONE;
                        r_cycles <= {CW{1'b0}};
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    r_cycles <= r_cycles + CW'(1);
                    if (!w_eq && (EARLY_EXIT != 0)) begin
                        r_res   <= w_verdict;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (r_idx == {IW{1'b0}}) begin
                        r_res   <= r_found ? r_held : w_verdict;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        // Without early exit only the first unequal slice decides.
                        if (!r_found && !w_eq) begin
                            r_found <= 1'b1;
                            r_held  <= w_verdict;
                        end
                        r_idx <= r_idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_res   <= CMP_NONE;
                        if (in_valid) begin
                            r_a      <= w_load_a;
                            r_b      <= w_load_b;
                            r_idx    <= IW'(NDIG - 1);
                            r_found  <= 1'b0;
                            r_held   <= CMP_NONE;
                            r_cycles <= {CW{1'b0}};
                            r_state  <= SCAN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_res   <= CMP_NONE;
                end
            endcase
        end
    end

    assign out_valid  = r_valid;
    assign out_lt     = r_res[2];
    assign out_eq     = r_res[1];
    assign out_gt     = r_res[0];
    assign out_cycles = r_cycles;

endmodule
